desloca_seq8: RTL and testbench



---
 rtl/desloca_pkg.sv | 19 +
 rtl/desloca_dir1_fill.sv | 21 ++
 rtl/desloca_seq8.sv | 121 ++++++++++++
 tb/tb_desloca_seq8.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/desloca_pkg.sv
// rtl/desloca_pkg.sv - shared constants and FSM encoding for the sequential right shifter
//
// Contents:
//   WIDTH   operand width (only 8 is supported)
//   SHW     shift-amount width, clog2(WIDTH)
//   state_t FSM encoding: OCIOSO=idle, DESLOCA=shifting, PRONTO=result ready

package desloca_pkg;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    DESLOCA = 2'b01,
    PRONTO  = 2'b10
  } state_t;

endpackage

// File: rtl/desloca_dir1_fill.sv
// rtl/desloca_dir1_fill.sv - combinational 1-bit right shift with explicit fill bit
//
// Ports:
//   din   [WIDTH-1:0]  value to shift
//   fill               bit inserted at the MSB
//   dout  [WIDTH-1:0]  {fill, din[WIDTH-1:1]}
//   sout               bit shifted out (din[0])

module desloca_dir1_fill
  import desloca_pkg::*;
(
  input  logic [WIDTH-1:0] din,
  input  logic             fill,
  output logic [WIDTH-1:0] dout,
  output logic             sout
);

  assign dout = {fill, din[WIDTH-1:1]};
  assign sout = din[0];

endmodule

// File: rtl/desloca_seq8.sv
// rtl/desloca_seq8.sv - iterative 8-bit right shifter, one position per clock, start/done handshake
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        request; accepted only when not busy (idle or result-ready)
//   a, shamt     operand and shift count, captured on an accepted start
//   arith        sign fill request (only when DESLOCA_ARITH_EN is defined)
//   y            registered result, held until the next result is produced
//   carry        last bit shifted out, 0 for shamt=0
//   zero         y==0, updated together with y
//   busy         high while shifting
//   done         one-cycle pulse when y/carry/zero are freshly valid
//
// Build option: DESLOCA_ARITH_EN adds the arith port and sign fill;
// without it the unit is a pure logical right shifter.

module desloca_seq8
  import desloca_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
`ifdef DESLOCA_ARITH_EN
  input  logic             arith,
`endif
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] shifted;
  logic             shout;
  logic             fill;

`ifdef DESLOCA_ARITH_EN
  logic arith_q;
  assign fill = arith_q & sreg[WIDTH-1];
`else
  assign fill = 1'b0;
`endif

  desloca_dir1_fill u_dir1 (
    .din  (sreg),
    .fill (fill),
    .dout (shifted),
    .sout (shout)
  );

  // y/carry/zero are written only on transitions into PRONTO, so the
  // consumer sees them stable through DESLOCA and OCIOSO. busy and done are
  // registered alongside the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= OCIOSO;
      sreg    <= '0;
      cnt     <= '0;
      y       <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef DESLOCA_ARITH_EN
      arith_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      busy <= 1'b0;
      case (state)
        OCIOSO, PRONTO: begin
          // Accepting in PRONTO gives back-to-back operation with no dead cycle.
          if (start) begin
            sreg <= a;
            cnt  <= shamt;
`ifdef DESLOCA_ARITH_EN
            arith_q <= arith;
`endif
            if (shamt != '0) begin
              state <= DESLOCA;
              busy  <= 1'b1;
            end else begin
              state <= PRONTO;
              done  <= 1'b1;
              y     <= a;
              carry <= 1'b0;
              zero  <= (a == '0);
            end
          end else begin
            state <= OCIOSO;
          end
        end
        DESLOCA: begin
          // start is ignored here; operand and count are not re-sampled.
          sreg <= shifted;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= PRONTO;
            done  <= 1'b1;
            y     <= shifted;
            carry <= shout;
            zero  <= (shifted == '0);
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_desloca_seq8.sv
// tb/tb_desloca_seq8.sv - self-checking bench for desloca_seq8 against a behavioural model

module tb_desloca_seq8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [2:0] shamt;
  logic       arith;
  logic [7:0] y;
  logic       carry;
  logic       zero;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  desloca_seq8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .shamt (shamt),
`ifdef DESLOCA_ARITH_EN
    .arith (arith),
`endif
    .y     (y),
    .carry (carry),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the whole shift in one step, plain arithmetic.
  function automatic logic [7:0] ref_y(input logic [7:0] av, input logic [2:0] sv, input logic ar);
    logic sign_fill;
`ifdef DESLOCA_ARITH_EN
    sign_fill = ar;
`else
    sign_fill = 1'b0;
`endif
    if (sign_fill) return 8'($signed(av) >>> sv);
    else           return av >> sv;
  endfunction

  function automatic logic ref_c(input logic [7:0] av, input logic [2:0] sv);
    if (sv == 3'd0) return 1'b0;
    return av[sv - 3'd1];
  endfunction

  // Model: an accepted start with count s publishes its result s edges later
  // (immediately for s=0); busy while a publication is outstanding.
  int         m_rem;
  logic [7:0] p_y, m_y;
  logic       p_c, m_c, m_z, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0; m_y <= 8'h00; m_c <= 1'b0; m_z <= 1'b0; m_done <= 1'b0;
      p_y <= 8'h00; p_c <= 1'b0;
    end else if (m_rem != 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_y <= p_y; m_c <= p_c; m_z <= (p_y == 8'h00); m_done <= 1'b1;
      end else begin
        m_done <= 1'b0;
      end
    end else if (start) begin
      if (shamt == 3'd0) begin
        m_y <= a; m_c <= 1'b0; m_z <= (a == 8'h00); m_done <= 1'b1;
      end else begin
        m_rem  <= int'(shamt);
        p_y    <= ref_y(a, shamt, arith);
        p_c    <= ref_c(a, shamt);
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_y",     32'(y),     32'(m_y));
      chk("cmp_carry", 32'(carry), 32'(m_c));
      chk("cmp_zero",  32'(zero),  32'(m_z));
      chk("cmp_busy",  32'(busy),  32'(m_rem != 0));
      chk("cmp_done",  32'(done),  32'(m_done));
    end
  end

  // Drive a one-cycle start; returns just after the accepting edge.
  task automatic start_op(input logic [7:0] av, input logic [2:0] sv, input logic ar);
    @(posedge clk); #1;
    start = 1'b1; a = av; shamt = sv; arith = ar;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); shamt = 3'($urandom); arith = 1'($urandom);
  endtask

  // Edges after the current point until done is seen (-1 on timeout).
  task automatic wait_done(output int lat, output int nb);
    lat = -1;
    nb  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (busy) nb++;
      @(posedge clk);
    end
  endtask

  task automatic op(input logic [7:0] av, input logic [2:0] sv, input logic ar,
                    input logic [7:0] ey, input logic ec, input logic ez, input string tag);
    int lat, nb;
    start_op(av, sv, ar);
    wait_done(lat, nb);
    chk({tag, "_latency"}, 32'(lat), 32'(sv));
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(sv));
    chk({tag, "_y"}, 32'(y), 32'(ey));
    chk({tag, "_carry"}, 32'(carry), 32'(ec));
    chk({tag, "_zero"}, 32'(zero), 32'(ez));
  endtask

  initial begin
    int lat, nb, ndone;
    rst_n = 1'b1; start = 1'b0; a = 8'h00; shamt = 3'd0; arith = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_y", 32'(y), 32'h00);
    chk("reset_carry", 32'(carry), 32'h0);
    chk("reset_zero", 32'(zero), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    op(8'hB4, 3'd3, 1'b0, 8'h16, 1'b1, 1'b0, "logical");
    op(8'h5A, 3'd0, 1'b0, 8'h5A, 1'b0, 1'b0, "noshift");
    op(8'h01, 3'd1, 1'b0, 8'h00, 1'b1, 1'b1, "zeroflag");
`ifdef DESLOCA_ARITH_EN
    op(8'h80, 3'd7, 1'b1, 8'hFF, 1'b0, 1'b0, "arith_fill");
`else
    op(8'h80, 3'd7, 1'b1, 8'h01, 1'b0, 1'b0, "arith_fill");
`endif

    // Start pulsed while busy must be ignored.
    start_op(8'hF0, 3'd4, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; a = 8'h0F; shamt = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, nb);
    chk("ignore_latency", 32'(lat), 32'd2);
    chk("ignore_y", 32'(y), 32'h0F);
    chk("ignore_carry", 32'(carry), 32'h0);

    // Back-to-back: start issued inside the done cycle.
    start = 1'b1; a = 8'h02; shamt = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, nb);
    chk("b2b_latency", 32'(lat), 32'd1);
    chk("b2b_y", 32'(y), 32'h01);
    chk("b2b_carry", 32'(carry), 32'h0);

    // Reset during the second shifting cycle of a 5-position shift.
    start_op(8'hC3, 3'd5, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_y", 32'(y), 32'h00);
    chk("midrst_carry", 32'(carry), 32'h0);
    chk("midrst_zero", 32'(zero), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    op(8'h96, 3'd2, 1'b0, 8'h25, 1'b1, 1'b0, "post_rst");

    // Random traffic: starts land in every state, including while busy.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      a     = 8'($urandom);
      shamt = 3'($urandom);
      arith = 1'($urandom);
    end
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
